acp_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the ACP datapath. It is the next-generation replacement for the fixed 256x16 show-ahead buffer. Adds:
- configurable width and depth
- selectable show-ahead or normal read mode
- full-range occupancy count and programmable almost-full/almost-empty flags
- sticky overflow/underflow flags and a peak-occupancy watermark
It sits between ACP request/response producers and consumers on sys_clk.

---
 rtl/acp_fifo_pkg.sv | 23 ++
 rtl/acp_fifo_ram.sv | 25 ++
 rtl/acp_sync_fifo.sv | 112 +++++++++++
 tb/tb_acp_sync_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acp_fifo_pkg.sv
// Shared constants, status bundle and parameter checking for the ACP single-clock FIFO.
package acp_fifo_pkg;

  localparam int ACP_DATA_W  = 256;
  localparam int ACP_FIFO_AW = 4;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } acp_fifo_stat_t;

  // Thresholds must lie inside the occupancy range of a 2**aw deep FIFO.
  function automatic bit acp_th_ok(input int aw, input int afull_th, input int aempty_th);
    int depth;
    if (aw < 1 || aw > 30) return 1'b0;
    depth = 1 << aw;
    return (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/acp_fifo_ram.sv
// DEPTH x DW storage: one synchronous write port, asynchronous read port.
module acp_fifo_ram
  import acp_fifo_pkg::*;
#(
  parameter int DW = ACP_DATA_W,
  parameter int AW = ACP_FIFO_AW
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  // Contents are deliberately left unreset.
  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/acp_sync_fifo.sv
// Parametrised single-clock FIFO: show-ahead or registered read, occupancy
// thresholds, sticky overflow/underflow and a peak-occupancy watermark.
module acp_sync_fifo
  import acp_fifo_pkg::*;
#(
  parameter int DW        = ACP_DATA_W,
  parameter int AW        = ACP_FIFO_AW,
  parameter int SHOWAHEAD = 1,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] fifo_wdata,
  input  logic          fifo_wren,
  output logic          fifo_full,
  output logic          fifo_afull,
  input  logic          fifo_rden,
  output logic [DW-1:0] fifo_rdata,
  output logic          fifo_empty,
  output logic          fifo_aempty,
  output logic [AW:0]   fifo_usedw,
  output logic [AW:0]   fifo_maxw,
  output logic          fifo_ovf,
  output logic          fifo_udf,
  input  logic          err_clr
);

  if (!acp_th_ok(AW, AFULL_TH, AEMPTY_TH)) begin : g_bad_param
    $error("acp_sync_fifo: illegal AW/AFULL_TH/AEMPTY_TH");
  end

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V = (AW+1)'(AEMPTY_TH);

  logic [AW:0]    wr_ptr, rd_ptr, usedw, usedw_nxt, maxw_q;
  logic           ovf_q, udf_q, wr_acc, rd_acc;
  logic [DW-1:0]  ram_rdata;
  acp_fifo_stat_t stat;

  // Extra pointer bit distinguishes full from empty; difference is occupancy.
  assign usedw = wr_ptr - rd_ptr;

  always_comb begin
    stat        = '0;
    stat.full   = (usedw == DEPTH_V);
    stat.afull  = (usedw >= AFULL_V);
    stat.empty  = (usedw == '0);
    stat.aempty = (usedw <= AEMPTY_V);
  end

  assign wr_acc = fifo_wren & ~stat.full;
  assign rd_acc = fifo_rden & ~stat.empty;

  always_comb begin
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc)      usedw_nxt = usedw + 1'b1;
    else if (!wr_acc && rd_acc) usedw_nxt = usedw - 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      maxw_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      // A fresh error in the clearing cycle keeps its flag set.
      if (fifo_wren && stat.full) ovf_q <= 1'b1;
      else if (err_clr)           ovf_q <= 1'b0;
      if (fifo_rden && stat.empty) udf_q <= 1'b1;
      else if (err_clr)            udf_q <= 1'b0;
      if (err_clr)                 maxw_q <= usedw;
      else if (usedw_nxt > maxw_q) maxw_q <= usedw_nxt;
    end
  end

  acp_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .sys_clk (sys_clk),
    .we      (wr_acc),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   (fifo_wdata),
    .raddr   (rd_ptr[AW-1:0]),
    .rdata   (ram_rdata)
  );

  if (SHOWAHEAD != 0) begin : g_showahead
    assign fifo_rdata = ram_rdata;
  end else begin : g_regread
    logic [DW-1:0] rdata_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)  rdata_q <= '0;
      else if (rd_acc) rdata_q <= ram_rdata;
    end
    assign fifo_rdata = rdata_q;
  end

  assign fifo_full   = stat.full;
  assign fifo_afull  = stat.afull;
  assign fifo_empty  = stat.empty;
  assign fifo_aempty = stat.aempty;
  assign fifo_usedw  = usedw;
  assign fifo_maxw   = maxw_q;
  assign fifo_ovf    = ovf_q;
  assign fifo_udf    = udf_q;

endmodule

// File: tb/tb_acp_sync_fifo.sv
// Scoreboard bench: a default show-ahead FIFO and an 8-deep registered-read FIFO.
`timescale 1ns/1ps
module tb_acp_sync_fifo;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Default instance: DW=256, AW=4, show-ahead, AFULL_TH=12, AEMPTY_TH=2
  logic [255:0] a_wdata, a_rdata;
  logic a_wren, a_rden, a_clr, a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf;
  logic [4:0] a_usedw, a_maxw;

  // Registered-read instance: DW=32, AW=3, AFULL_TH=6, AEMPTY_TH=1
  logic [31:0] w_wdata, w_rdata;
  logic w_wren, w_rden, w_clr, w_full, w_afull, w_empty, w_aempty, w_ovf, w_udf;
  logic [3:0] w_usedw, w_maxw;

  acp_sync_fifo dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .fifo_wdata(a_wdata), .fifo_wren(a_wren), .fifo_full(a_full), .fifo_afull(a_afull),
    .fifo_rden(a_rden), .fifo_rdata(a_rdata), .fifo_empty(a_empty), .fifo_aempty(a_aempty),
    .fifo_usedw(a_usedw), .fifo_maxw(a_maxw), .fifo_ovf(a_ovf), .fifo_udf(a_udf),
    .err_clr(a_clr)
  );

  acp_sync_fifo #(.DW(32), .AW(3), .SHOWAHEAD(0), .AFULL_TH(6), .AEMPTY_TH(1)) dut_w (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .fifo_wdata(w_wdata), .fifo_wren(w_wren), .fifo_full(w_full), .fifo_afull(w_afull),
    .fifo_rden(w_rden), .fifo_rdata(w_rdata), .fifo_empty(w_empty), .fifo_aempty(w_aempty),
    .fifo_usedw(w_usedw), .fifo_maxw(w_maxw), .fifo_ovf(w_ovf), .fifo_udf(w_udf),
    .err_clr(w_clr)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [255:0] q_a[$];
  logic [31:0]  q_w[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Show-ahead monitor: the head word is on rdata in the cycle it is acknowledged.
  always @(negedge sys_clk) begin
    if (sys_rst_n && a_rden && !a_empty) begin
      if (q_a.size() == 0) chk("a_unexpected_read", 256'(a_usedw), 256'(0));
      else chk("a_rdata", a_rdata, q_a.pop_front());
    end
  end

  // Registered-read monitor: rdata is checked one cycle after the accepted read.
  logic w_pend = 1'b0;
  always @(negedge sys_clk) begin
    if (w_pend) begin
      if (q_w.size() == 0) chk("w_unexpected_read", 256'(w_usedw), 256'(0));
      else chk("w_rdata", 256'(w_rdata), 256'(q_w.pop_front()));
    end
    w_pend = sys_rst_n && w_rden && !w_empty;
  end

  task automatic chk_a_reset();
    chk("a_rst_usedw", 256'(a_usedw), 256'(0));
    chk("a_rst_maxw", 256'(a_maxw), 256'(0));
    chk("a_rst_empty", 256'(a_empty), 256'(1));
    chk("a_rst_aempty", 256'(a_aempty), 256'(1));
    chk("a_rst_full", 256'(a_full), 256'(0));
    chk("a_rst_afull", 256'(a_afull), 256'(0));
    chk("a_rst_ovf", 256'(a_ovf), 256'(0));
    chk("a_rst_udf", 256'(a_udf), 256'(0));
  endtask

  initial begin
    int cnt, peak, written, cyc;
    logic wr, rd;
    a_wdata = '0; a_wren = 0; a_rden = 0; a_clr = 0;
    w_wdata = '0; w_wren = 0; w_rden = 0; w_clr = 0;

    // Reset state
    #12;
    chk_a_reset();
    chk("w_rst_rdata", 256'(w_rdata), 256'(0));
    sys_rst_n = 1'b1;

    // 1: fill with 0x01..0x10, then one overflow attempt
    for (int i = 1; i <= 16; i++) begin
      a_wren = 1; a_wdata = 256'(i); q_a.push_back(256'(i));
      tick();
      chk("t1_usedw", 256'(a_usedw), 256'(i));
      chk("t1_afull", 256'(a_afull), 256'(i >= 12));
      chk("t1_full", 256'(a_full), 256'(i == 16));
    end
    a_wdata = 256'h11;
    tick();
    a_wren = 0;
    chk("t1_ovf", 256'(a_ovf), 256'(1));
    chk("t1_usedw_hold", 256'(a_usedw), 256'(16));
    chk("t1_maxw", 256'(a_maxw), 256'(16));

    // 2: show-ahead drain, then one underflow attempt
    a_rden = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t2_usedw", 256'(a_usedw), 256'(16 - i));
      chk("t2_aempty", 256'(a_aempty), 256'((16 - i) <= 2));
      chk("t2_empty", 256'(a_empty), 256'(i == 16));
    end
    tick();
    a_rden = 0;
    chk("t2_udf", 256'(a_udf), 256'(1));
    chk("t2_usedw0", 256'(a_usedw), 256'(0));

    // 3a: simultaneous read/write at usedw=5
    a_wren = 1;
    for (int i = 0; i < 5; i++) begin
      a_wdata = 256'(32'h20 + i); q_a.push_back(256'(32'h20 + i));
      tick();
    end
    a_rden = 1;
    for (int i = 5; i < 15; i++) begin
      a_wdata = 256'(32'h20 + i); q_a.push_back(256'(32'h20 + i));
      tick();
      chk("t3_usedw5", 256'(a_usedw), 256'(5));
    end
    a_wren = 0;
    repeat (5) tick();
    a_rden = 0;
    chk("t3_drained", 256'(a_empty), 256'(1));

    // err_clr alone clears the sticky flags; maxw takes current usedw
    a_clr = 1; tick(); a_clr = 0;
    chk("t3_clr_ovf", 256'(a_ovf), 256'(0));
    chk("t3_clr_udf", 256'(a_udf), 256'(0));
    chk("t3_clr_maxw", 256'(a_maxw), 256'(0));

    // 3b: read+write while empty: write taken, read flagged
    a_wren = 1; a_rden = 1; a_wdata = 256'h30; q_a.push_back(256'h30);
    tick();
    a_wren = 0; a_rden = 0;
    chk("t3b_usedw", 256'(a_usedw), 256'(1));
    chk("t3b_udf", 256'(a_udf), 256'(1));
    chk("t3b_ovf", 256'(a_ovf), 256'(0));

    // 3c: read+write while full: read taken, write dropped
    a_wren = 1;
    for (int i = 1; i <= 15; i++) begin
      a_wdata = 256'(32'h30 + i); q_a.push_back(256'(32'h30 + i));
      tick();
    end
    chk("t3c_full", 256'(a_full), 256'(1));
    a_rden = 1; a_wdata = 256'hEE;
    tick();
    a_rden = 0; a_wren = 0;
    chk("t3c_usedw", 256'(a_usedw), 256'(15));
    chk("t3c_ovf", 256'(a_ovf), 256'(1));

    // 6: err_clr concurrent with overflow keeps ovf
    a_wren = 1; a_wdata = 256'h40; q_a.push_back(256'h40);
    tick();
    a_wdata = 256'hEF; a_clr = 1;
    tick();
    a_wren = 0;
    chk("t6_ovf_kept", 256'(a_ovf), 256'(1));
    chk("t6_udf_clr", 256'(a_udf), 256'(0));
    chk("t6_maxw_load", 256'(a_maxw), 256'(16));
    tick();
    a_clr = 0;
    chk("t6_ovf_clr", 256'(a_ovf), 256'(0));

    // 6: asynchronous reset between edges during a read burst
    a_rden = 1;
    repeat (3) tick();
    chk("t6_pre_rst_usedw", 256'(a_usedw), 256'(13));
    #1 sys_rst_n = 1'b0;
    #1 chk_a_reset();
    a_rden = 0;
    q_a.delete();
    tick();
    sys_rst_n = 1'b1;
    chk("t6_post_rst_empty", 256'(a_empty), 256'(1));

    // 4: registered read mode
    chk("t4_rst_rdata", 256'(w_rdata), 256'(0));
    w_wren = 1;
    w_wdata = 32'hAA; q_w.push_back(32'hAA); tick();
    w_wdata = 32'hBB; q_w.push_back(32'hBB); tick();
    w_wren = 0;
    chk("t4_rdata_before", 256'(w_rdata), 256'(0));
    w_rden = 1; tick(); w_rden = 0;
    chk("t4_rdata_aa", 256'(w_rdata), 256'(32'hAA));
    tick();
    chk("t4_rdata_hold_aa", 256'(w_rdata), 256'(32'hAA));
    w_rden = 1; tick(); w_rden = 0;
    chk("t4_rdata_bb", 256'(w_rdata), 256'(32'hBB));
    repeat (3) tick();
    chk("t4_rdata_hold_bb", 256'(w_rdata), 256'(32'hBB));
    chk("t4_empty", 256'(w_empty), 256'(1));

    // 5: random push/pop across pointer wraps
    w_clr = 1; tick(); w_clr = 0;
    chk("t5_maxw_clr", 256'(w_maxw), 256'(0));
    cnt = 0; peak = 0; written = 0; cyc = 0;
    while ((written < 100 || cnt > 0) && cyc < 3000) begin
      wr = (written < 100) && ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) < 5);
      w_wren = wr; w_rden = rd; w_wdata = $urandom;
      if (wr && cnt < 8) begin
        q_w.push_back(w_wdata);
        written++;
      end
      tick();
      cnt = cnt + ((wr && cnt < 8) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
      if (cnt > peak) peak = cnt;
      chk("t5_usedw", 256'(w_usedw), 256'(cnt));
      chk("t5_usedw_le8", 256'(w_usedw <= 4'd8), 256'(1));
      chk("t5_afull", 256'(w_afull), 256'(cnt >= 6));
      chk("t5_aempty", 256'(w_aempty), 256'(cnt <= 1));
      cyc++;
    end
    w_wren = 0; w_rden = 0;
    chk("t5_finished", 256'(cyc < 3000), 256'(1));
    tick(); tick();
    chk("t5_maxw_peak", 256'(w_maxw), 256'(peak));
    chk("t5_peak_full", 256'(peak), 256'(8));
    chk("t5_qw_empty", 256'(q_w.size()), 256'(0));
    chk("qa_empty", 256'(q_a.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
